// File: rtl/proc_pkg.sv
// Shared definitions for the proc instruction sequencer: opcode encodings,
// opcode field position and the sequencer state type.
package proc_pkg;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;

  localparam logic [2:0] MV  = 3'b000;
  localparam logic [2:0] MVI = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;
  localparam logic [2:0] HLT = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    IMM,
    WAIT,
    PAUSE,
    HALTED,
    ERROR
  } seq_state_t;

  function automatic logic [2:0] opcode_of(input logic [8:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

  // Codes 100/101/110 reach proc unchanged and behave like ADD/SUB there.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == ADD) || (op == SUB) || (op[2] && (op != HLT));
  endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Program-ROM read port plus the DIN/Run/Done handshake towards proc.
interface proc_sequencer_if #(
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_data;
  logic [8:0]        DIN;
  logic              Run;
  logic              Done;

  modport master (
    output mem_addr,
    output DIN,
    output Run,
    input  mem_data,
    input  Done
  );

  modport slave (
    input  mem_addr,
    input  DIN,
    input  Run,
    output mem_data,
    output Done
  );

endinterface

// File: rtl/wdog_counter.sv
// Clear/enable cycle counter that flags the TIMEOUT-th consecutive enabled cycle.
module wdog_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  // The cycle being counted is included, so the flag rises while count is TIMEOUT-1.
  assign expire = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/proc_sequencer.sv
// Sequences the 9-bit proc from a synchronous program ROM, with start/halt/step
// control, a HLT opcode, a retired-instruction count and a Done watchdog.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Go,
  input  logic              Halt,
  input  logic              StepMode,
  proc_sequencer_if.master  bus,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Err,
  output logic [15:0]       retired
);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nxt;
  logic [2:0]        opcode;
  logic              halt_seen;
  logic              retire;
  logic              wd_clear;
  logic              wd_expire;

  assign opcode = opcode_of(bus.mem_data);

  wdog_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .Clock (Clock),
    .Reset (Reset),
    .clear (wd_clear),
    .enable(state == WAIT),
    .expire(wd_expire)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A Halt anywhere between ISSUE and retirement turns the next boundary into PAUSE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q      <= '0;
      retired   <= '0;
      halt_seen <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (retire) begin
        retired <= retired + 16'd1;
      end
      if (state == ISSUE) begin
        halt_seen <= Halt;
      end else if ((state == IMM) || (state == WAIT)) begin
        halt_seen <= halt_seen | Halt;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    retire       = 1'b0;
    wd_clear     = 1'b0;
    bus.mem_addr = pc_q;
    bus.DIN      = '0;
    bus.Run      = 1'b0;

    case (state)
      IDLE: begin
        if (Go) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.DIN      = bus.mem_data;
        bus.mem_addr = pc_q + 1'b1;
        if (opcode == HLT) begin
          state_nxt = HALTED;
        end else begin
          bus.Run = 1'b1;
          if (opcode == MVI) begin
            state_nxt = IMM;
          end else begin
            state_nxt = WAIT;
            wd_clear  = 1'b1;
          end
        end
      end
      IMM: begin
        bus.DIN = bus.mem_data;
        if (bus.Done) begin
          retire = 1'b1;
          pc_nxt = pc_q + ADDR_W'(2);
        end else begin
          state_nxt = ERROR;
        end
      end
      WAIT: begin
        if (bus.Done) begin
          retire = 1'b1;
          pc_nxt = pc_q + 1'b1;
        end else if (wd_expire) begin
          state_nxt = ERROR;
        end
      end
      PAUSE: begin
        if (Halt) begin
          state_nxt = HALTED;
        end else if (Go) begin
          state_nxt = FETCH;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (retire) begin
      state_nxt = (StepMode || halt_seen || Halt) ? PAUSE : FETCH;
    end
  end

  assign PC     = pc_q;
  assign Busy   = (state == FETCH) || (state == ISSUE) || (state == IMM) || (state == WAIT);
  assign Halted = (state == HALTED);
  assign Err    = (state == ERROR);

endmodule

// File: tb/tb_proc_sequencer.sv
`timescale 1ns/1ps
// Bench for proc_sequencer: synchronous ROM plus a cycle-level proc stand-in,
// directed scenarios then random programs checked against a program-level model.
module tb_proc_sequencer;
  import proc_pkg::*;

  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              Clock    = 1'b0;
  logic              Reset    = 1'b1;
  logic              Go       = 1'b0;
  logic              Halt     = 1'b0;
  logic              StepMode = 1'b0;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Halted;
  logic              Err;
  logic [15:0]       retired;

  proc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  proc_sequencer #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Go      (Go),
    .Halt    (Halt),
    .StepMode(StepMode),
    .bus     (bus),
    .PC      (PC),
    .Busy    (Busy),
    .Halted  (Halted),
    .Err     (Err),
    .retired (retired)
  );

  always #5 Clock = ~Clock;

  logic [8:0] rom [DEPTH];

  always @(posedge Clock) bus.mem_data <= rom[bus.mem_addr];

  // proc stand-in: T0 latches IR on Run; MV/MVI finish in T1, ALU ops in T3.
  logic [8:0] preg [8];
  logic [8:0] ir         = '0;
  int         tstep      = 0;
  logic       stall_done = 1'b0;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tstep <= 0;
    end else if (tstep == 0) begin
      if (bus.Run) begin
        ir    <= bus.DIN;
        tstep <= 1;
      end
    end else if (ir[8:6] == MV) begin
      preg[ir[5:3]] <= preg[ir[2:0]];
      tstep         <= 0;
    end else if (ir[8:6] == MVI) begin
      preg[ir[5:3]] <= bus.DIN;
      tstep         <= 0;
    end else if (tstep < 3) begin
      tstep <= tstep + 1;
    end else begin
      preg[ir[5:3]] <= ir[6] ? preg[ir[5:3]] - preg[ir[2:0]] : preg[ir[5:3]] + preg[ir[2:0]];
      tstep         <= 0;
    end
  end

  assign bus.Done = !stall_done && (((tstep == 1) && (ir[8:7] == 2'b00)) || (tstep == 3));

  int         checks    = 0;
  int         errors    = 0;
  int         cyc       = 0;
  int         busy_cnt  = 0;
  int         run_cnt   = 0;
  int         other_cnt = 0;
  int         run_cyc [$];
  logic       run_prev      = 1'b0;
  logic [8:0] din_after_run = '0;
  logic [8:0] ref_regs [8];

  int exp_step_pc   [4] = '{2, 3, 4, 4};
  int exp_step_halt [4] = '{0, 0, 0, 1};
  int n;
  int c_run;
  int r0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    busy_cnt  = 0;
    run_cnt   = 0;
    other_cnt = 0;
    run_prev  = 1'b0;
    run_cyc.delete();
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
    if (Busy) busy_cnt++;
    else if (!Halted && !Err) other_cnt++;
    if (run_prev) din_after_run = bus.DIN;
    if (bus.Run) begin
      run_cnt++;
      run_cyc.push_back(cyc);
    end
    run_prev = bus.Run;
  endtask

  // mode 0: Halted or Err, 1: Busy low, 2: Err, 3: Run pulse
  task automatic wait_for(input int mode, input int budget, input string tag, output int cycles);
    bit hit = 1'b0;
    cycles = 0;
    while (!hit && (cycles < budget)) begin
      tick();
      cycles++;
      case (mode)
        0:       hit = Halted || Err;
        1:       hit = !Busy;
        2:       hit = Err;
        default: hit = bus.Run;
      endcase
    end
    check({tag, " wait expired"}, {31'b0, ~hit}, 32'd0);
  endtask

  task automatic apply_reset();
    Go         = 1'b0;
    Halt       = 1'b0;
    StepMode   = 1'b0;
    stall_done = 1'b0;
    Reset      = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    clear_stats();
  endtask

  task automatic pulse_go();
    Go = 1'b1;
    tick();
    Go = 1'b0;
  endtask

  task automatic rom_fill_hlt();
    for (int i = 0; i < DEPTH; i++) rom[i] = {HLT, 6'o00};
  endtask

  task automatic init_program();
    for (int i = 0; i < 8; i++) begin
      rom[2*i]     = {MVI, 3'(i), 3'b000};
      rom[2*i + 1] = 9'($urandom);
    end
    rom[16] = {HLT, 6'o00};
  endtask

  task automatic gen_program();
    int p   = 0;
    int len = $urandom_range(4, 26);
    for (int i = 0; i < DEPTH; i++) rom[i] = 9'($urandom);
    while (p < len) begin
      logic [2:0] op = 3'($urandom_range(0, 6));
      rom[p] = {op, 3'($urandom), 3'($urandom)};
      if (op == MVI) begin
        rom[p + 1] = 9'($urandom);
        p += 2;
      end else begin
        p++;
      end
    end
    rom[p] = {HLT, 6'($urandom)};
  endtask

  // Program-level model: walks the ROM instruction by instruction until HLT.
  task automatic ref_run(output int e_pc, output int e_ret, output int e_busy);
    int         p = 0;
    logic [8:0] w;
    logic [2:0] op, x, y;
    e_ret  = 0;
    e_busy = 0;
    for (int k = 0; k < 64; k++) begin
      w  = rom[ADDR_W'(p)];
      op = w[8:6];
      x  = w[5:3];
      y  = w[2:0];
      if (op == HLT) begin
        e_busy += 2;
        break;
      end
      e_ret++;
      if (op == MV) begin
        ref_regs[x] = ref_regs[y];
        e_busy += 3;
        p = (p + 1) % DEPTH;
      end else if (op == MVI) begin
        ref_regs[x] = rom[ADDR_W'((p + 1) % DEPTH)];
        e_busy += 3;
        p = (p + 2) % DEPTH;
      end else begin
        ref_regs[x] = op[0] ? ref_regs[x] - ref_regs[y] : ref_regs[x] + ref_regs[y];
        e_busy += 5;
        p = (p + 1) % DEPTH;
      end
    end
    e_pc = p;
  endtask

  task automatic run_and_check(input bit step);
    int e_pc, e_ret, e_busy, cycles;
    ref_run(e_pc, e_ret, e_busy);
    apply_reset();
    StepMode = step;
    Go       = 1'b1;
    wait_for(0, 1000, "rand run", cycles);
    Go = 1'b0;
    check("rand halted", Halted, 1);
    check("rand PC", PC, e_pc);
    check("rand retired", retired, e_ret);
    check("rand busy cycles", busy_cnt, e_busy);
    check("rand Run pulses", run_cnt, e_ret);
    check("rand pause cycles", other_cnt, step ? e_ret : 0);
    for (int i = 0; i < 8; i++) check($sformatf("rand R%0d", i), preg[i], ref_regs[i]);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    // reset values while Reset is held
    repeat (2) @(posedge Clock);
    #1;
    check("reset Run", bus.Run, 0);
    check("reset DIN", bus.DIN, 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset Busy", Busy, 0);
    check("reset Halted", Halted, 0);
    check("reset Err", Err, 0);
    check("reset PC", PC, 0);
    check("reset retired", retired, 0);

    // mvi R0,5 ; HLT
    rom_fill_hlt();
    rom[0] = 9'o100;
    rom[1] = 9'd5;
    apply_reset();
    pulse_go();
    wait_for(0, 100, "mvi run", n);
    check("mvi Run pulses", run_cnt, 1);
    check("mvi immediate DIN", din_after_run, 5);
    check("mvi Halted", Halted, 1);
    check("mvi PC", PC, 2);
    check("mvi retired", retired, 1);
    check("mvi R0", preg[0], 5);

    // preload R0=7, then mv R1,R0 ; add R0,R1 ; HLT
    rom_fill_hlt();
    rom[0] = 9'o100;
    rom[1] = 9'd7;
    apply_reset();
    pulse_go();
    wait_for(0, 100, "preload run", n);
    rom_fill_hlt();
    rom[0] = 9'o010;
    rom[1] = 9'o201;
    apply_reset();
    pulse_go();
    wait_for(0, 100, "mv-add run", n);
    check("mv-add Run pulses", run_cyc.size(), 2);
    if (run_cyc.size() == 2) begin
      check("mv length", run_cyc[1] - run_cyc[0], 3);
      check("add length to HALTED", cyc - run_cyc[1], 6);
    end
    check("mv-add retired", retired, 2);
    check("mv-add R0 doubled", preg[0], 14);
    check("mv-add R1", preg[1], 7);

    // single-step: mvi R2,9 ; mv R3,R2 ; add R2,R3 ; HLT
    rom_fill_hlt();
    rom[0] = 9'o120;
    rom[1] = 9'd9;
    rom[2] = 9'o032;
    rom[3] = 9'o223;
    apply_reset();
    StepMode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse_go();
      wait_for(1, 50, "step", n);
      check($sformatf("step %0d PC", i), PC, exp_step_pc[i]);
      check($sformatf("step %0d Halted", i), Halted, exp_step_halt[i]);
    end
    check("step retired", retired, 3);
    check("step R2", preg[2], 18);

    // mvi at the last address takes its immediate from address 0
    for (int i = 2; i < 31; i++) rom[i] = 9'o010;
    rom[0]  = 9'o150;
    rom[1]  = 9'o700;
    rom[31] = 9'o140;
    apply_reset();
    pulse_go();
    wait_for(0, 300, "wrap run", n);
    check("wrap Halted", Halted, 1);
    check("wrap PC", PC, 1);
    check("wrap retired", retired, 31);
    check("wrap R4 immediate", preg[4], 9'o150);

    // Done never arrives on an add
    rom_fill_hlt();
    rom[0] = 9'o201;
    apply_reset();
    stall_done = 1'b1;
    pulse_go();
    wait_for(3, 10, "timeout issue", n);
    c_run = cyc;
    wait_for(2, 40, "timeout error", n);
    check("timeout latency", cyc - c_run, TIMEOUT + 1);
    r0 = run_cnt;
    repeat (5) tick();
    check("no Run after error", run_cnt, r0);
    check("Err held", Err, 1);
    check("Busy low in error", Busy, 0);

    // asynchronous reset in the WAIT of the second instruction
    rom_fill_hlt();
    rom[0] = 9'o010;
    rom[1] = 9'o201;
    apply_reset();
    pulse_go();
    wait_for(3, 10, "pre-reset issue 0", n);
    wait_for(3, 10, "pre-reset issue 1", n);
    tick();
    #2 Reset = 1'b1;
    #1;
    check("async reset PC", PC, 0);
    check("async reset retired", retired, 0);
    check("async reset mem_addr", bus.mem_addr, 0);
    check("async reset Busy", Busy, 0);
    check("async reset Run", bus.Run, 0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    clear_stats();
    pulse_go();
    check("restart fetch addr", bus.mem_addr, 0);
    check("restart Busy", Busy, 1);
    wait_for(0, 100, "restart run", n);
    check("restart retired", retired, 2);
    check("restart PC", PC, 2);

    // Halt together with Done in the last WAIT cycle of an add
    rom_fill_hlt();
    rom[0] = 9'o211;
    rom[1] = 9'o021;
    apply_reset();
    pulse_go();
    wait_for(3, 10, "halt issue", n);
    repeat (3) tick();
    Halt = 1'b1;
    tick();
    check("halt pause Busy", Busy, 0);
    check("halt pause Halted", Halted, 0);
    check("halt pause PC", PC, 1);
    check("halt pause retired", retired, 1);
    tick();
    Halt = 1'b0;
    check("halt from pause Halted", Halted, 1);
    check("halt from pause PC", PC, 1);

    // random programs, the first one loads every register
    for (int t = 0; t < 8; t++) begin
      if (t == 0) init_program();
      else gen_program();
      run_and_check(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
